mac_filter_sched: RTL and testbench

- Time-multiplexes one combinational `mac` instance across NumFilters output filters (channels) of a convolution layer.
- Holds a per-filter weight bank, loaded over a ready/valid stream.
- Accepts one kernel window per handshake and replays it against each filter's weights on consecutive cycles.
- Emits one signed result per filter on a ready/valid output stream. Sits between the line-buffer/window generator and the activation/requantise stage.

---
 rtl/mac_filter_sched.sv | 162 ++++++++++++++++
 tb/tb_mac_filter_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_filter_sched.sv
`default_nettype none
// ============================================================================
// Module      : mac_filter_sched
// Description : Shares one combinational mac across NUM_FILTERS output
//               filters. Holds a per-filter weight bank, latches one kernel
//               window per handshake and replays it against each filter's
//               weights on consecutive cycles, emitting one result per filter.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_filter_sched #(
    parameter int KERNEL_WIDTH  = 3,
    parameter int WIDTH_IN      = 1,
    parameter int WIDTH_OUT     = 32,
    parameter int WEIGHT_WIDTH  = 2,
    parameter int NUM_FILTERS   = 4,
    localparam int c_KERNEL_AREA = KERNEL_WIDTH * KERNEL_WIDTH,
    localparam int c_FILT_IDX_W  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    reload_i,
    input  logic                                    weight_valid_i,
    output logic                                    weight_ready_o,
    input  logic [c_KERNEL_AREA*WEIGHT_WIDTH-1:0]   weight_data_i,
    input  logic                                    valid_i,
    output logic                                    ready_o,
    input  logic [c_KERNEL_AREA*WIDTH_IN-1:0]       window_i,
    output logic [c_KERNEL_AREA*WIDTH_IN-1:0]       mac_window_o,
    output logic [c_KERNEL_AREA*WEIGHT_WIDTH-1:0]   mac_weights_o,
    input  logic [WIDTH_OUT-1:0]                    mac_data_i,
    output logic                                    valid_o,
    input  logic                                    ready_i,
    output logic [WIDTH_OUT-1:0]                    data_o,
    output logic [c_FILT_IDX_W-1:0]                 filt_idx_o,
    output logic                                    last_o
);

    localparam int c_WEIGHT_BITS = c_KERNEL_AREA * WEIGHT_WIDTH;
    localparam int c_WINDOW_BITS = c_KERNEL_AREA * WIDTH_IN;
    localparam logic [c_FILT_IDX_W-1:0] c_LAST_IDX = c_FILT_IDX_W'(NUM_FILTERS - 1);
    localparam logic [c_FILT_IDX_W-1:0] c_ONE      = c_FILT_IDX_W'(1);

    localparam logic [1:0] c_S_LOAD = 2'd0;
    localparam logic [1:0] c_S_IDLE = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_FILT_IDX_W-1:0]  r_wptr;
    logic [c_FILT_IDX_W-1:0]  r_idx;
    logic [c_WINDOW_BITS-1:0] r_window;
    logic [c_WEIGHT_BITS-1:0] r_bank [NUM_FILTERS];
    logic                     r_reload_pend;

    logic w_last;
    logic w_wptr_last;
    logic w_reload_req;
    logic w_wt_hs;
    logic w_win_hs;
    logic w_step;

    assign w_last       = (r_idx == c_LAST_IDX);
    assign w_wptr_last  = (r_wptr == c_LAST_IDX);
    assign w_reload_req = reload_i | r_reload_pend;
    assign w_wt_hs      = weight_valid_i & weight_ready_o;
    assign w_win_hs     = valid_i & ready_o;
    assign w_step       = (r_state == c_S_RUN) & ready_i & ~w_last;

    // The mac sees the latched window and the current filter's weights; its
    // result is passed straight through as the output data.
    assign mac_window_o  = r_window;
    assign mac_weights_o = r_bank[r_idx];
    assign data_o        = mac_data_i;

    // Next-state and handshake decode; reload always wins over a new window.
    always_comb begin
        w_state_nxt    = r_state;
        weight_ready_o = 1'b0;
        ready_o        = 1'b0;
        valid_o        = 1'b0;
        last_o         = 1'b0;
        filt_idx_o     = '0;
        case (r_state)
            c_S_LOAD: begin
                weight_ready_o = 1'b1;
                if (weight_valid_i && w_wptr_last) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_IDLE: begin
                if (w_reload_req) begin
                    w_state_nxt = c_S_LOAD;
                end else begin
                    ready_o = 1'b1;
                    if (valid_i) begin
                        w_state_nxt = c_S_RUN;
                    end
                end
            end
            c_S_RUN: begin
                valid_o    = 1'b1;
                filt_idx_o = r_idx;
                last_o     = w_last;
                if (ready_i && w_last) begin
                    if (w_reload_req) begin
                        w_state_nxt = c_S_LOAD;
                    end else begin
                        // Last result leaving: a waiting window is taken in the
                        // same cycle to keep the mac busy back to back.
                        ready_o = 1'b1;
                        if (!valid_i) begin
                            w_state_nxt = c_S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_LOAD;
            end
        endcase
    end

    // State, pointers, window latch and deferred-reload flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= c_S_LOAD;
            r_wptr        <= '0;
            r_idx         <= '0;
            r_window      <= '0;
            r_reload_pend <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wt_hs) begin
                r_wptr <= w_wptr_last ? '0 : r_wptr + c_ONE;
            end
            if (w_win_hs) begin
                r_window <= window_i;
                r_idx    <= '0;
            end else if (w_step) begin
                r_idx <= r_idx + c_ONE;
            end
            if (w_state_nxt == c_S_LOAD) begin
                r_reload_pend <= 1'b0;
            end else if (reload_i && (r_state == c_S_RUN)) begin
                r_reload_pend <= 1'b1;
            end
        end
    end

    // Weight bank; cleared on reset so a full reload is always required.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                r_bank[i] <= '0;
            end
        end else if (w_wt_hs) begin
            r_bank[r_wptr] <= weight_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_filter_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_filter_sched
// Description : Self-checking bench for mac_filter_sched with a queue-based
//               scoreboard and a dot-product reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_filter_sched;

    localparam int KW = 3;
    localparam int KA = KW * KW;
    localparam int WI = 1;
    localparam int WO = 32;
    localparam int WW = 2;
    localparam int NF = 4;
    localparam int WD = KA * WW;
    localparam int WN = KA * WI;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    // main instance (four filters)
    logic          reload_i = 1'b0, wv = 1'b0, wr, valid_i = 1'b0, ready_o;
    logic [WD-1:0] wd = '0, mac_wt;
    logic [WN-1:0] window_i = '0, mac_win;
    logic [WO-1:0] mac_data, data_o;
    logic          valid_o, last_o;
    logic          ready_i = 1'b1;
    logic [1:0]    filt_idx;

    // single-filter instance
    logic          wv1 = 1'b0, wr1, valid1 = 1'b0, ready1_o;
    logic [WD-1:0] wd1 = '0, mac_wt1;
    logic [WN-1:0] win1 = '0, mac_win1;
    logic [WO-1:0] mac_data1, data1;
    logic          valid1_o, last1;
    logic [0:0]    filt_idx1;

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  rdy_rand = 1'b0;

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t          q[$];
    logic [WD-1:0] mbank [NF];
    int            mwptr = 0;

    // Signed weights times zero-extended pixels, summed modulo 2^32.
    function automatic int dot(input logic [WD-1:0] w, input logic [WN-1:0] x);
        int s = 0;
        for (int i = 0; i < KA; i++) begin
            s += int'($signed(w[i*WW +: WW])) * int'({1'b0, x[i*WI +: WI]});
        end
        return s;
    endfunction

    function automatic logic [WD-1:0] rep(input logic [WW-1:0] v, input bit alt);
        logic [WD-1:0] r = '0;
        for (int i = 0; i < KA; i++) begin
            r[i*WW +: WW] = (alt && (i % 2 == 1)) ? '0 : v;
        end
        return r;
    endfunction

    assign mac_data  = dot(mac_wt, mac_win);
    assign mac_data1 = dot(mac_wt1, mac_win1);

    mac_filter_sched #(
        .KERNEL_WIDTH(KW), .WIDTH_IN(WI), .WIDTH_OUT(WO),
        .WEIGHT_WIDTH(WW), .NUM_FILTERS(NF)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .reload_i(reload_i),
        .weight_valid_i(wv), .weight_ready_o(wr), .weight_data_i(wd),
        .valid_i(valid_i), .ready_o(ready_o), .window_i(window_i),
        .mac_window_o(mac_win), .mac_weights_o(mac_wt), .mac_data_i(mac_data),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .filt_idx_o(filt_idx), .last_o(last_o)
    );

    mac_filter_sched #(
        .KERNEL_WIDTH(KW), .WIDTH_IN(WI), .WIDTH_OUT(WO),
        .WEIGHT_WIDTH(WW), .NUM_FILTERS(1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .reload_i(1'b0),
        .weight_valid_i(wv1), .weight_ready_o(wr1), .weight_data_i(wd1),
        .valid_i(valid1), .ready_o(ready1_o), .window_i(win1),
        .mac_window_o(mac_win1), .mac_weights_o(mac_wt1), .mac_data_i(mac_data1),
        .valid_o(valid1_o), .ready_i(1'b1), .data_o(data1),
        .filt_idx_o(filt_idx1), .last_o(last1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    // Scoreboard: tracks weight and window handshakes, checks every result.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    timeout("unexpected_result");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_data", data_o, e.data);
                    chk("sb_idx", {30'd0, filt_idx}, e.idx);
                    chk("sb_last", {31'd0, last_o}, {31'd0, e.last});
                end
            end
            if (valid_i && ready_o) begin
                for (int f = 0; f < NF; f++) begin
                    q.push_back('{dot(mbank[f], window_i), f, (f == NF - 1)});
                end
            end
            if (wv && wr) begin
                mbank[mwptr] = wd;
                mwptr = (mwptr + 1) % NF;
            end
        end
    end

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic model_reset();
        q.delete();
        mwptr = 0;
        for (int f = 0; f < NF; f++) mbank[f] = '0;
    endtask

    task automatic load_bank(input logic [WD-1:0] b0, b1, b2, b3);
        logic [WD-1:0] b [NF];
        bit hs;
        b = '{b0, b1, b2, b3};
        for (int f = 0; f < NF; f++) begin
            wv = 1'b0;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            wv = 1'b1;
            wd = b[f];
            hs = 1'b0;
            for (int n = 0; n < 400 && !hs; n++) begin
                @(negedge clk);
                hs = wr;
                @(posedge clk); #1;
            end
            if (!hs) timeout("weight_load");
        end
        wv = 1'b0;
    endtask

    task automatic send_window(input logic [WN-1:0] w);
        bit acc = 1'b0;
        bit lod = 1'b0;
        valid_i  = 1'b1;
        window_i = w;
        for (int n = 0; n < 400 && !acc && !lod; n++) begin
            @(negedge clk);
            acc = ready_o;
            lod = wr;
        end
        if (!acc && !lod) timeout("window_accept");
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 1000 && !done; n++) begin
            @(negedge clk);
            done = (q.size() == 0) && !valid_o;
        end
        if (!done) timeout("drain");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1 [NF];
        logic [WN-1:0] ones;
        logic [WD-1:0] w1;
        logic [WN-1:0] prevwin;
        t1   = '{9, -9, 5, 0};
        ones = '1;
        model_reset();

        // reset values
        @(negedge clk);
        chk("rst_valid", {31'd0, valid_o}, 0);
        chk("rst_ready", {31'd0, ready_o}, 0);
        chk("rst_last", {31'd0, last_o}, 0);
        chk("rst_idx", {30'd0, filt_idx}, 0);
        chk("rst_wready", {31'd0, wr}, 1);
        chk("rst_wready1", {31'd0, wr1}, 1);
        @(posedge clk); #1 rst_ni = 1'b1;

        // basic results and latency
        load_bank(rep(2'b01, 0), rep(2'b11, 0), rep(2'b01, 1), rep(2'b00, 0));
        @(negedge clk);
        chk("idle_ready", {31'd0, ready_o}, 1);
        chk("idle_wready", {31'd0, wr}, 0);
        @(posedge clk); #1;
        send_window(ones);
        for (int k = 0; k < NF; k++) begin
            @(negedge clk);
            chk("t1_valid", {31'd0, valid_o}, 1);
            chk("t1_data", data_o, t1[k]);
            chk("t1_idx", {30'd0, filt_idx}, k);
            chk("t1_last", {31'd0, last_o}, (k == NF - 1) ? 1 : 0);
            @(posedge clk); #1;
        end
        wait_drain();

        // stall on filter 1
        send_window(ones);
        @(posedge clk); #1 ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t2_valid", {31'd0, valid_o}, 1);
            chk("t2_data", data_o, -9);
            chk("t2_idx", {30'd0, filt_idx}, 1);
        end
        @(posedge clk); #1 ready_i = 1'b1;
        wait_drain();

        // back-to-back windows
        valid_i  = 1'b1;
        window_i = ones;
        @(negedge clk);
        chk("t3_idle_ready", {31'd0, ready_o}, 1);
        @(posedge clk); #1 window_i = '0;
        for (int k = 0; k < 2 * NF; k++) begin
            @(negedge clk);
            chk("t3_valid", {31'd0, valid_o}, 1);
            chk("t3_ready", {31'd0, ready_o}, (k % NF == NF - 1) ? 1 : 0);
            @(posedge clk); #1;
            if (k == NF - 1) valid_i = 1'b0;
        end
        wait_drain();

        // reload requested during filter 1
        send_window(ones);
        @(posedge clk); #1 reload_i = 1'b1;
        @(posedge clk); #1 reload_i = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("t4_wready", {31'd0, wr}, 1);
        chk("t4_ready", {31'd0, ready_o}, 0);
        @(posedge clk); #1;
        load_bank(rep(2'b01, 0), rep(2'b01, 0), rep(2'b01, 0), rep(2'b01, 0));
        send_window(ones);
        wait_drain();

        // reset in the middle of a window
        send_window(ones);
        @(posedge clk); #1 rst_ni = 1'b0;
        model_reset();
        #1;
        chk("t5_valid", {31'd0, valid_o}, 0);
        @(posedge clk); #1 rst_ni = 1'b1;
        valid_i  = 1'b1;
        window_i = WN'($urandom);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_ready", {31'd0, ready_o}, 0);
            chk("t5_wready", {31'd0, wr}, 1);
        end
        @(posedge clk); #1;
        load_bank(WD'($urandom), WD'($urandom), WD'($urandom), WD'($urandom));
        send_window(window_i);
        wait_drain();

        // randomized traffic with backpressure and reloads
        rdy_rand = 1'b1;
        for (int it = 0; it < 60; it++) begin
            bit in_load;
            @(negedge clk);
            in_load = wr;
            @(posedge clk); #1;
            if (in_load) begin
                load_bank(WD'($urandom), WD'($urandom), WD'($urandom), WD'($urandom));
            end else if ($urandom_range(0, 9) == 0) begin
                reload_i = 1'b1;
                @(posedge clk); #1 reload_i = 1'b0;
            end else begin
                send_window(WN'($urandom));
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        rdy_rand = 1'b0;
        @(posedge clk); #2 ready_i = 1'b1;
        wait_drain();

        // single-filter configuration
        w1  = WD'($urandom);
        wv1 = 1'b1;
        wd1 = w1;
        @(negedge clk);
        chk("t6_wready", {31'd0, wr1}, 1);
        @(posedge clk); #1 wv1 = 1'b0;
        valid1  = 1'b1;
        win1    = WN'($urandom);
        prevwin = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("t6_ready", {31'd0, ready1_o}, 1);
            chk("t6_valid", {31'd0, valid1_o}, (k > 0) ? 1 : 0);
            if (k > 0) begin
                chk("t6_data", data1, dot(w1, prevwin));
                chk("t6_idx", {31'd0, filt_idx1}, 0);
                chk("t6_last", {31'd0, last1}, 1);
            end
            @(posedge clk); #1;
            prevwin = win1;
            win1    = WN'($urandom);
        end
        valid1 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
